// File: rtl/corr_sched.sv
// rtl/corr_sched.sv - lag-sweep scheduler driving the fetch/MAC/shifter chain
// Optional peak tracker enabled by defining CORR_SCHED_PEAK_EN.
module corr_sched #(
  parameter int ADDR_W    = 8,
  parameter int COUNT_W   = 5,
  parameter int LAG_W     = 4,
  parameter int SHIFT_LAT = 1
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic [LAG_W-1:0]   nlags,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               fetch_start,
  output logic [ADDR_W-1:0]  fetch_addr,
  output logic [COUNT_W-1:0] fetch_count,
  input  logic               mac_done,
  input  logic [15:0]        shift_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_data,
  output logic [LAG_W-1:0]   res_lag
`ifdef CORR_SCHED_PEAK_EN
  ,
  output logic signed [15:0] peak_data,
  output logic [LAG_W-1:0]   peak_lag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_OUT
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [LAG_W-1:0]   r_nlags;
  logic [LAG_W-1:0]   r_lag;
  logic [2:0]         r_settle;
  logic               w_last_lag;
  logic [LAG_W-1:0]   w_next_lag;

  assign w_last_lag = (r_lag == r_nlags - 1'b1);
  assign w_next_lag = r_lag + 1'b1;

`ifdef CORR_SCHED_PEAK_EN
  // Magnitude with -32768 saturated so it fits the 15-bit positive range.
  function automatic logic [15:0] mag(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7fff;
    else if (v[15])    return 16'h0000 - v;
    else               return v;
  endfunction
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_nlags     <= '0;
      r_lag       <= '0;
      r_settle    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      fetch_start <= 1'b0;
      fetch_addr  <= '0;
      fetch_count <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_lag     <= '0;
`ifdef CORR_SCHED_PEAK_EN
      peak_data   <= '0;
      peak_lag    <= '0;
`endif
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      fetch_start <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state   <= S_IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_base      <= base_addr;
              r_nlags     <= nlags;
              r_lag       <= '0;
              fetch_count <= count;
              if (count == '0 || nlags == '0) begin
                err <= 1'b1;
              end else begin
                // fetch_start is raised on entry so it is high for the whole ISSUE cycle
                r_state     <= S_ISSUE;
                busy        <= 1'b1;
                fetch_start <= 1'b1;
                fetch_addr  <= base_addr;
`ifdef CORR_SCHED_PEAK_EN
                peak_data   <= '0;
                peak_lag    <= '0;
`endif
              end
            end
          end
          S_ISSUE: r_state <= S_WAIT;
          S_WAIT: begin
            if (mac_done) begin
              r_state  <= S_SETTLE;
              r_settle <= 3'(SHIFT_LAT);
            end
          end
          S_SETTLE: begin
            if (r_settle <= 3'd1) begin
              res_data  <= shift_in;
              res_lag   <= r_lag;
              res_valid <= 1'b1;
              r_state   <= S_OUT;
            end else begin
              r_settle <= r_settle - 3'd1;
            end
          end
          S_OUT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
`ifdef CORR_SCHED_PEAK_EN
              if (mag(res_data) > mag(peak_data)) begin
                peak_data <= res_data;
                peak_lag  <= res_lag;
              end
`endif
              if (w_last_lag) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_lag       <= w_next_lag;
                fetch_addr  <= r_base + ADDR_W'(w_next_lag);
                fetch_start <= 1'b1;
                r_state     <= S_ISSUE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_corr_sched.sv
// tb/tb_corr_sched.sv - directed self-checking bench for corr_sched
// Define CORR_SCHED_PEAK_EN to also exercise the peak tracker.
module tb_corr_sched;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  base_addr;
  logic [4:0]  count;
  logic [3:0]  nlags;
  logic        busy, done, err, fetch_start;
  logic [7:0]  fetch_addr;
  logic [4:0]  fetch_count;
  logic        mac_done;
  logic [15:0] shift_in;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_lag;
`ifdef CORR_SCHED_PEAK_EN
  logic signed [15:0] peak_data;
  logic [3:0]         peak_lag;
`endif

  always #5 ck = ~ck;

  corr_sched dut (
    .ck(ck), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .nlags(nlags),
    .busy(busy), .done(done), .err(err),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_count(fetch_count),
    .mac_done(mac_done), .shift_in(shift_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_lag(res_lag)
`ifdef CORR_SCHED_PEAK_EN
    , .peak_data(peak_data), .peak_lag(peak_lag)
`endif
  );

  int passed = 0;
  int total  = 0;

  // Mock MAC/shifter: mac_done 14 cycles after each fetch_start, data from vals[]
  logic        mac_en;
  logic        mock_done, man_done;
  logic [15:0] mock_shift, man_shift;
  logic [15:0] vals [8];
  int          mock_cnt, fidx;
  assign mac_done = mock_done | man_done;
  assign shift_in = mac_en ? mock_shift : man_shift;

  always @(negedge ck) begin
    mock_done = 1'b0;
    if (mac_en) begin
      if (fetch_start) begin
        mock_shift = vals[fidx[2:0]];
        fidx++;
        mock_cnt = 14;
      end else if (mock_cnt > 0) begin
        mock_cnt--;
        if (mock_cnt == 0) mock_done = 1'b1;
      end
    end
  end

  // Observation of fetches, transfers and pulses
  logic [7:0]  addr_q[$];
  logic [15:0] dat_q[$];
  logic [3:0]  lag_q[$];
  int          done_cnt, err_cnt, busy_at_done;

  always @(negedge ck) begin
    if (rst_n) begin
      if (fetch_start) addr_q.push_back(fetch_addr);
      if (res_valid && res_ready) begin
        dat_q.push_back(res_data);
        lag_q.push_back(res_lag);
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_at_done++;
      end
      if (err) err_cnt++;
    end
  end

  task automatic clear_obs();
    addr_q.delete(); dat_q.delete(); lag_q.delete();
    done_cnt = 0; err_cnt = 0; busy_at_done = 0; fidx = 0; mock_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [4:0] c, input logic [3:0] n);
    base_addr = b; count = c; nlags = n; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge ck);
    total++;
    if (done_cnt !== d0 + 1) $display("FAIL %s_done: got %0d done pulses want %0d", name, done_cnt - d0, 1);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge ck);
    total++;
    if ({busy, done, err, fetch_start, res_valid} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, fetch_start, res_valid});
    else passed++;
    total++;
    if ({fetch_addr, fetch_count} !== 13'h0) $display("FAIL reset_fetch: got %h want 0", {fetch_addr, fetch_count});
    else passed++;
    total++;
    if ({res_data, res_lag} !== 20'h0) $display("FAIL reset_res: got %h want 0", {res_data, res_lag});
    else passed++;
    rst_n = 1'b1;
    @(negedge ck);
  endtask

  task automatic test_basic();
    clear_obs();
    mac_en = 1'b1; res_ready = 1'b1;
    vals[0] = 16'h0111; vals[1] = 16'h0222; vals[2] = 16'h0333;
    pulse_start(8'h00, 5'd12, 4'd3);
    total++;
    if ({fetch_start, busy, fetch_addr, fetch_count} !== {1'b1, 1'b1, 8'h00, 5'd12})
      $display("FAIL basic_issue: got fs=%b busy=%b addr=%h cnt=%0d want 1 1 00 12", fetch_start, busy, fetch_addr, fetch_count);
    else passed++;
    wait_done("basic");
    total++;
    if (addr_q.size() != 3 || addr_q[0] !== 8'h00 || addr_q[1] !== 8'h01 || addr_q[2] !== 8'h02)
      $display("FAIL basic_addr: got %p want 00 01 02", addr_q);
    else passed++;
    total++;
    if (lag_q.size() != 3 || lag_q[0] !== 4'd0 || lag_q[1] !== 4'd1 || lag_q[2] !== 4'd2)
      $display("FAIL basic_lag: got %p want 0 1 2", lag_q);
    else passed++;
    total++;
    if (dat_q.size() != 3 || dat_q[0] !== 16'h0111 || dat_q[1] !== 16'h0222 || dat_q[2] !== 16'h0333)
      $display("FAIL basic_data: got %p want 0111 0222 0333", dat_q);
    else passed++;
    repeat (5) @(negedge ck);
    total++;
    if (done_cnt !== 1 || busy_at_done !== 0)
      $display("FAIL basic_done_busy: got done=%0d busy_at_done=%0d want 1 0", done_cnt, busy_at_done);
    else passed++;
  endtask

  task automatic test_wrap();
    clear_obs();
    pulse_start(8'hFE, 5'd3, 4'd4);
    wait_done("wrap");
    total++;
    if (addr_q.size() != 4 || addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF || addr_q[2] !== 8'h00 || addr_q[3] !== 8'h01)
      $display("FAIL wrap_addr: got %p want FE FF 00 01", addr_q);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [3:0]  l;
    int          bad = 0;
    clear_obs();
    vals[0] = 16'h1000; vals[1] = 16'h2001; vals[2] = 16'h3002;
    pulse_start(8'h10, 5'd4, 4'd3);
    for (int i = 0; i < 500 && addr_q.size() < 2; i++) @(negedge ck);
    res_ready = 1'b0;
    for (int i = 0; i < 500 && !res_valid; i++) @(negedge ck);
    d = res_data; l = res_lag;
    total++;
    if (res_valid !== 1'b1 || l !== 4'd1 || d !== 16'h2001)
      $display("FAIL bp_first: got v=%b lag=%0d data=%h want 1 1 2001", res_valid, l, d);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (res_valid !== 1'b1 || res_data !== d || res_lag !== l || fetch_start !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0 || addr_q.size() != 2)
      $display("FAIL bp_hold: got %0d unstable cycles, %0d fetches want 0 2", bad, addr_q.size());
    else passed++;
    res_ready = 1'b1;
    @(negedge ck);
    total++;
    if ({res_valid, fetch_start, fetch_addr} !== {1'b0, 1'b1, 8'h12})
      $display("FAIL bp_resume: got v=%b fs=%b addr=%h want 0 1 12", res_valid, fetch_start, fetch_addr);
    else passed++;
    wait_done("bp");
    total++;
    if (dat_q.size() != 3 || dat_q[2] !== 16'h3002) $display("FAIL bp_count: got %p want 3 results", dat_q);
    else passed++;
  endtask

  task automatic test_mac_latency();
    clear_obs();
    mac_en = 1'b0; man_shift = 16'hBEEF;
    pulse_start(8'h05, 5'd1, 4'd1);
    @(negedge ck);
    man_done = 1'b1;
    @(negedge ck);
    man_done = 1'b0;
    total++;
    if (res_valid !== 1'b0) $display("FAIL lat_early: got res_valid=%b want 0", res_valid);
    else passed++;
    @(negedge ck);
    total++;
    if ({res_valid, res_data, res_lag} !== {1'b1, 16'hBEEF, 4'd0})
      $display("FAIL lat_valid: got v=%b data=%h lag=%0d want 1 BEEF 0", res_valid, res_data, res_lag);
    else passed++;
    wait_done("lat");
    mac_en = 1'b1;
  endtask

  task automatic test_err();
    clear_obs();
    pulse_start(8'h00, 5'd0, 4'd2);
    total++;
    if ({err, busy, fetch_start} !== 3'b100) $display("FAIL err_count0: got %b want 100", {err, busy, fetch_start});
    else passed++;
    @(negedge ck);
    total++;
    if ({err, busy} !== 2'b00) $display("FAIL err_single: got %b want 00", {err, busy});
    else passed++;
    pulse_start(8'h00, 5'd3, 4'd0);
    total++;
    if ({err, busy, fetch_start} !== 3'b100) $display("FAIL err_nlags0: got %b want 100", {err, busy, fetch_start});
    else passed++;
    @(negedge ck);
    clear_obs();
    pulse_start(8'h40, 5'd2, 4'd2);
    repeat (5) @(negedge ck);
    pulse_start(8'h80, 5'd0, 4'd5);
    total++;
    if ({err, busy} !== 2'b01) $display("FAIL start_ignored: got err=%b busy=%b want 0 1", err, busy);
    else passed++;
    wait_done("ignore");
    total++;
    if (addr_q.size() != 2 || addr_q[0] !== 8'h40 || addr_q[1] !== 8'h41 || err_cnt !== 0)
      $display("FAIL ignore_addr: got %p err=%0d want 40 41 err=0", addr_q, err_cnt);
    else passed++;
  endtask

  task automatic test_abort();
    int bad = 0;
    clear_obs();
    mac_en = 1'b0;
    pulse_start(8'h20, 5'd3, 4'd2);
    @(negedge ck);
    abort = 1'b1;
    @(negedge ck);
    abort = 1'b0;
    total++;
    if ({busy, fetch_start, res_valid} !== 3'b000) $display("FAIL abort_idle: got %b want 000", {busy, fetch_start, res_valid});
    else passed++;
    man_done = 1'b1;
    @(negedge ck);
    man_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid || busy || fetch_start) bad++;
      @(negedge ck);
    end
    total++;
    if (bad !== 0 || done_cnt !== 0) $display("FAIL abort_stray: got %0d active cycles, %0d done want 0 0", bad, done_cnt);
    else passed++;
    mac_en = 1'b1;
    clear_obs();
    pulse_start(8'h30, 5'd2, 4'd2);
    wait_done("restart");
    total++;
    if (addr_q.size() != 2 || addr_q[0] !== 8'h30 || lag_q.size() != 2 || lag_q[0] !== 4'd0 || lag_q[1] !== 4'd1)
      $display("FAIL restart: got addr %p lag %p want 30 31 / 0 1", addr_q, lag_q);
    else passed++;
  endtask

  task automatic test_reset_in_out();
    clear_obs();
    res_ready = 1'b0;
    pulse_start(8'h50, 5'd2, 4'd2);
    for (int i = 0; i < 500 && !res_valid; i++) @(negedge ck);
    total++;
    if (res_valid !== 1'b1) $display("FAIL rst_reach_out: got res_valid=%b want 1", res_valid);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({res_valid, busy, res_data} !== 18'h0) $display("FAIL rst_async: got v=%b busy=%b data=%h want 0 0 0", res_valid, busy, res_data);
    else passed++;
    @(negedge ck);
    rst_n = 1'b1; res_ready = 1'b1;
    @(negedge ck);
  endtask

`ifdef CORR_SCHED_PEAK_EN
  task automatic test_peak();
    clear_obs();
    vals[0] = 16'd100; vals[1] = 16'hFED4; vals[2] = 16'd300;
    pulse_start(8'h00, 5'd4, 4'd3);
    wait_done("peak");
    total++;
    if (peak_data !== -16'sd300 || peak_lag !== 4'd1)
      $display("FAIL peak: got data=%0d lag=%0d want -300 1", peak_data, peak_lag);
    else passed++;
  endtask
`endif

  initial begin
    start = 1'b0; abort = 1'b0; base_addr = '0; count = '0; nlags = '0;
    res_ready = 1'b1; mac_en = 1'b1; man_done = 1'b0; mock_done = 1'b0;
    man_shift = '0; mock_shift = '0;
    for (int i = 0; i < 8; i++) vals[i] = '0;
    clear_obs();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_mac_latency();
    test_err();
    test_abort();
    test_reset_in_out();
`ifdef CORR_SCHED_PEAK_EN
    test_peak();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/corr_sched.md
# corr_sched

Lag-sweep scheduler for the correlator datapath. On one `start` it runs the x-RAM fetch unit, the MAC and the shifter once per lag. Each lag reads `count` samples starting at `base_addr + lag`, for lags 0..`nlags`-1. Each scaled 16-bit result is presented downstream on a valid/ready handshake tagged with its lag. It replaces the ad-hoc start/wait sequencing in the testbench and sits between the host/control registers and the `corr_fetch`/`mac`/`shifter` chain.

## Interface
- `ADDR_W`, 8, x-RAM address width
- `COUNT_W`, 5, sample-count width (matches fetch unit)
- `LAG_W`, 4, lag index width
- `SHIFT_LAT`, 1, cycles from `mac_done` until `shift_in` is valid (1..7)

Ports:
- `ck`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin sweep (single-cycle pulse, sampled in IDLE only)
- `abort`  in  1  cancel sweep
- `base_addr`  in  ADDR_W  first sample address of lag 0
- `count`  in  COUNT_W  samples per lag
- `nlags`  in  LAG_W  number of lags
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse, sweep completed
- `err`  out  1  one-cycle pulse, start rejected
- `fetch_start`  out  1  one-cycle start to fetch unit
- `fetch_addr`  out  ADDR_W  fetch start address
- `fetch_count`  out  COUNT_W  fetch count
- `mac_done`  in  1  MAC finished current lag
- `shift_in`  in  16  shifter output
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts
- `res_data`  out  16  result
- `res_lag`  out  LAG_W  lag of result

## Operation
- States: IDLE, ISSUE, WAIT, SETTLE, OUT.
- IDLE: on `start`, latch `base_addr`, `count`, `nlags`, and clear the lag counter.
  - If the latched `count`==0 or `nlags`==0: pulse `err`, stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE: assert `fetch_start` for exactly one cycle.
  - `fetch_addr` = latched base + lag, mod 2^ADDR_W (wrap-around is legal).
  - `fetch_count` = latched count.
  - Next state WAIT.
- WAIT: hold until `mac_done`, then go to SETTLE with the settle counter loaded to `SHIFT_LAT`.
- SETTLE: decrement. At the final cycle, capture `shift_in` into `res_data` and the lag into `res_lag`, then go to OUT.
- OUT: `res_valid` is high. Transfer happens on `res_valid & res_ready`.
  - After transfer, if lag == latched `nlags`-1: go to IDLE and pulse `done`.
  - Otherwise increment lag and go to ISSUE.
- `res_data`/`res_lag` are stable while `res_valid` is high and not yet accepted.
- `start` while not IDLE: ignored, no `err`.
- `abort` (any state except IDLE): next state IDLE.
  - `res_valid` drops and no `done` is pulsed.
  - A later `mac_done` is ignored in IDLE.
  - `abort` and `start` together in IDLE: `start` wins (`abort` has no effect in IDLE).
- `mac_done` outside WAIT: ignored.
- Mid-operation reset (`rst_n` low): immediate return to IDLE, all outputs go to their reset values asynchronously.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `fetch_start`, `res_valid` all 0; `fetch_addr`, `fetch_count`, `res_data`, `res_lag` all 0.
- All outputs are registered.
- `start` sampled at edge N → `fetch_start` high during cycle N+1, `busy` high from N+1.
- `mac_done` sampled at edge M → `res_valid` high from cycle M+`SHIFT_LAT`+1.
- Accept at edge A:
  - Intermediate lag: `res_valid` low and `fetch_start` high in cycle A+1.
  - Last lag: `busy` low and `done` high in cycle A+1.
- Per-lag overhead beyond fetch+MAC: `SHIFT_LAT`+2 cycles plus any ready stall.
- Back-pressure holds the sweep; no results are dropped.

## Configuration
- `CORR_SCHED_PEAK_EN` defined: adds outputs `peak_data` (16, signed) and `peak_lag` (LAG_W).
  - Both are cleared at sweep start.
  - Updated on each transfer when |`res_data`| > |`peak_data`| (strict; the earlier lag wins ties; -32768 treated as 32767).
  - Both hold their values after `done`.
- Not defined: these ports and logic are absent; behaviour is otherwise identical.

## Test plan
- base 0x00, count 12, nlags 3, `res_ready` tied 1, mock MAC `mac_done` 14 cycles after `fetch_start` → `fetch_addr` 0x00, 0x01, 0x02; three results with `res_lag` 0, 1, 2; one `done` pulse; `busy` drops the same cycle as `done`.
- base 0xFE, nlags 4 → `fetch_addr` 0xFE, 0xFF, 0x00, 0x01.
- `res_ready` low for 20 cycles at lag 1 → `res_valid`/`res_data`/`res_lag` held stable; no `fetch_start` until accepted.
- count 0 or nlags 0 → single `err` pulse, `busy` stays 0, no `fetch_start`; `start` during a sweep → ignored.
- `abort` in WAIT, then a stray `mac_done` → IDLE next cycle, no `res_valid`, no `done`; a new `start` restarts at lag 0. `rst_n` low in OUT → `res_valid` 0 immediately.
- With `CORR_SCHED_PEAK_EN`: results 100, -300, 300 → `peak_data` -300, `peak_lag` 1.
